// File: rtl/ts_framer_gen_if.sv
// Byte-stream bus between the receiver, the framer and the packet demux.
interface ts_framer_gen_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  logic [DW-1:0] din;
  logic          dinstb;
  logic [DW-1:0] dout;
  logic          doutstb;
  logic          doutsync;
  logic [CW-1:0] doutpos;
  logic          locked;
  logic [1:0]    lock_state;
  logic          sync_err;

  modport master (
    output din, dinstb,
    input  dout, doutstb, doutsync, doutpos, locked, lock_state, sync_err
  );

  modport slave (
    input  din, dinstb,
    output dout, doutstb, doutsync, doutpos, locked, lock_state, sync_err
  );
endinterface

// File: rtl/ts_framer_gen.sv
// Sync-byte framer for fixed-length packets: majority vote over a sync
// timestamp history selects the frame phase; a flywheel rides out lost syncs.
module ts_framer_gen #(
  parameter int            DW          = 8,
  parameter int            FRAME_LEN   = 188,
  parameter int            CW          = 8,
  parameter logic [DW-1:0] SYNC        = 8'h47,
  parameter logic [DW-1:0] SYNC_INV    = 8'hB8,
  parameter bit            ACCEPT_INV  = 1'b0,
  parameter int            HIST        = 6,
  parameter int            LOCK_THRESH = 4,
  parameter int            MISS_MAX    = 3
) (
  input  logic          clk,
  input  logic          reset,
  ts_framer_gen_if.slave bus
);
  localparam logic [1:0] HUNT   = 2'b00;
  localparam logic [1:0] LOCKED = 2'b10;
  localparam logic [1:0] FLY    = 2'b11;

  localparam int MW = $clog2(MISS_MAX + 1);
  localparam int NW = $clog2(HIST + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW:0]   FL   = (CW + 1)'(FRAME_LEN);
  localparam logic [NW-1:0] THR  = NW'(LOCK_THRESH);
  localparam logic [MW-1:0] MMAX = MW'(MISS_MAX);

  if (LOCK_THRESH > HIST) begin : g_bad_thresh
    $error("ts_framer_gen: LOCK_THRESH must not exceed HIST");
  end
  if ((1 << CW) < FRAME_LEN) begin : g_bad_cw
    $error("ts_framer_gen: CW too narrow for FRAME_LEN");
  end

  logic [CW-1:0] cnt_q, cnt_d, syncidx_q, syncidx_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [1:0]    state_q, state_d;
  logic [HIST-1:0] hv_q, hv_d;
  logic [CW-1:0] hts_q [HIST];
  logic [CW-1:0] hts_d [HIST];
  logic [DW-1:0] dout_q, dout_d;
  logic          stb_q, stb_d, sync_q, sync_d, err_q, err_d;
  logic [CW-1:0] pos_q, pos_d;

  logic          is_sync, at_idx, flush;
  logic [NW-1:0] nmatch;
  logic [CW:0]   diff;

  always_comb begin
    is_sync = (bus.din == SYNC) || (ACCEPT_INV && (bus.din == SYNC_INV));
    at_idx  = (cnt_q == syncidx_q);
    nmatch  = '0;
    for (int unsigned i = 0; i < HIST; i++) begin
      if (hv_q[i] && (hts_q[i] == cnt_q)) nmatch = nmatch + 1'b1;
    end

    cnt_d     = cnt_q;
    syncidx_d = syncidx_q;
    miss_d    = miss_q;
    state_d   = state_q;
    hv_d      = hv_q;
    hts_d     = hts_q;
    dout_d    = dout_q;
    pos_d     = pos_q;
    stb_d     = 1'b0;
    sync_d    = 1'b0;
    err_d     = 1'b0;
    flush     = 1'b0;
    diff      = '0;

    if (bus.dinstb) begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      dout_d = bus.din;
      stb_d  = 1'b1;

      case (state_q)
        HUNT: begin
          if (is_sync && (nmatch >= THR)) begin
            state_d   = LOCKED;
            syncidx_d = cnt_q;
            sync_d    = 1'b1;
            miss_d    = '0;
          end
        end
        LOCKED: begin
          if (at_idx) begin
            if (is_sync) begin
              sync_d = 1'b1;
            end else begin
              err_d = 1'b1;
              if (MISS_MAX == 1) begin
                state_d = HUNT;
                flush   = 1'b1;
                miss_d  = '0;
              end else begin
                state_d = FLY;
                miss_d  = MW'(1);
                sync_d  = 1'b1;
              end
            end
          end
        end
        FLY: begin
          if (at_idx) begin
            if (is_sync) begin
              state_d = LOCKED;
              miss_d  = '0;
              sync_d  = 1'b1;
            end else begin
              err_d = 1'b1;
              if ((miss_q + 1'b1) == MMAX) begin
                state_d = HUNT;
                flush   = 1'b1;
                miss_d  = '0;
              end else begin
                miss_d = miss_q + 1'b1;
                sync_d = 1'b1;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase

      // Push uses the pre-push history for nmatch; a flush never coincides
      // with a push because it only happens on a missing sync.
      if (is_sync) begin
        for (int unsigned i = 1; i < HIST; i++) begin
          hv_d[i]  = hv_q[i-1];
          hts_d[i] = hts_q[i-1];
        end
        hv_d[0]  = 1'b1;
        hts_d[0] = cnt_q;
      end
      if (flush) hv_d = '0;

      if (state_d[1]) begin
        diff = {1'b0, cnt_q} - {1'b0, syncidx_d};
        if (diff[CW]) diff = diff + FL;
        pos_d = diff[CW-1:0];
      end else begin
        pos_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      syncidx_q <= '0;
      miss_q    <= '0;
      state_q   <= HUNT;
      hv_q      <= '0;
      for (int unsigned i = 0; i < HIST; i++) hts_q[i] <= '0;
      dout_q    <= '0;
      stb_q     <= 1'b0;
      sync_q    <= 1'b0;
      err_q     <= 1'b0;
      pos_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      syncidx_q <= syncidx_d;
      miss_q    <= miss_d;
      state_q   <= state_d;
      hv_q      <= hv_d;
      hts_q     <= hts_d;
      dout_q    <= dout_d;
      stb_q     <= stb_d;
      sync_q    <= sync_d;
      err_q     <= err_d;
      pos_q     <= pos_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.doutstb    = stb_q;
  assign bus.doutsync   = sync_q;
  assign bus.doutpos    = pos_q;
  assign bus.locked     = state_q[1];
  assign bus.lock_state = state_q;
  assign bus.sync_err   = err_q;
endmodule
